// File: rtl/uart_stream_pkg.sv
// Shared definitions for the UART burst scheduler: FSM encoding, counter widths
// and the default burst/gap shape.
package uart_stream_pkg;

  localparam int unsigned DEF_BURST_LEN = 1024;
  localparam int unsigned DEF_GAP_TICKS = 16;

  // Sized so BURST_LEN up to 2047 and GAP_TICKS up to 31 never wrap.
  localparam int unsigned CNT_W = 11;
  localparam int unsigned GAP_W = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_RD    = 3'd2,
    S_LATCH = 3'd3,
    S_SEND  = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/txd_stream_sched_if.sv
// FIFO-read and UART-load signals between the burst scheduler (master) and its
// surroundings (slave).
interface txd_stream_sched_if;
  // sys_rd is a one-cycle read strobe, issued only while fifo_empty is low; sys_data
  // is valid the cycle after the read is taken. txd_en is a one-cycle load strobe,
  // issued only while txd_busy is low, and txd_data is stable while it is high.
  logic       fifo_empty;
  logic [7:0] sys_data;
  logic       sys_rd;
  logic       txd_busy;
  logic       txd_en;
  logic [7:0] txd_data;

  modport master (
    input  fifo_empty,
    input  sys_data,
    input  txd_busy,
    output sys_rd,
    output txd_en,
    output txd_data
  );

  modport slave (
    output fifo_empty,
    output sys_data,
    output txd_busy,
    input  sys_rd,
    input  txd_en,
    input  txd_data
  );
endinterface

// File: rtl/bps_gap_counter.sv
// Counts baud ticks between two UART loads; saturates at GAP_TICKS so it can
// never wrap while the scheduler waits in GAP.
module bps_gap_counter
  import uart_stream_pkg::*;
#(
  parameter int unsigned GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic tick_i,
  output logic reached_o
);
  localparam logic [GAP_W-1:0] LIMIT = GAP_W'(GAP_TICKS);

  logic [GAP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + GAP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign reached_o = (cnt_q == LIMIT);

endmodule

// File: rtl/txd_stream_sched.sv
// Burst scheduler: reads BURST_LEN bytes from a FIFO one at a time and loads each
// into a UART, leaving GAP_TICKS baud ticks between consecutive loads.
module txd_stream_sched
  import uart_stream_pkg::*;
#(
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               clk_bps,
  output logic               busy,
  output logic               done,
  txd_stream_sched_if.master bus,
  output state_t             state_o
);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN);

  state_t           state_q, state_d;
  logic             sys_rd_q, sys_rd_d;
  logic             txd_en_q, txd_en_d;
  logic             done_q, done_d;
  logic [7:0]       txd_data_q, txd_data_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             gap_clr;
  logic             gap_tick;
  logic             gap_reached;

  // Ticks outside GAP must not advance the spacing count.
  assign gap_tick = clk_bps && (state_q == S_GAP);

  bps_gap_counter #(
    .GAP_TICKS(GAP_TICKS)
  ) u_gap (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (gap_clr),
    .tick_i   (gap_tick),
    .reached_o(gap_reached)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sys_rd_q   <= 1'b0;
      txd_en_q   <= 1'b0;
      done_q     <= 1'b0;
      txd_data_q <= 8'h00;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sys_rd_q   <= sys_rd_d;
      txd_en_q   <= txd_en_d;
      done_q     <= done_d;
      txd_data_q <= txd_data_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sys_rd_d   = 1'b0;
    txd_en_d   = 1'b0;
    done_d     = 1'b0;
    txd_data_d = txd_data_q;
    byte_cnt_d = byte_cnt_q;
    gap_clr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!bus.fifo_empty) begin
          sys_rd_d = 1'b1;
          state_d  = S_RD;
        end
      end
      S_RD: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        txd_data_d = bus.sys_data;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (!bus.txd_busy) begin
          txd_en_d   = 1'b1;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          gap_clr    = 1'b1;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        // CHECK is only re-entered with bytes still owed, so reads never exceed BURST_LEN.
        if (gap_reached) begin
          if (byte_cnt_q == BURST_LAST) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_DONE: begin
        byte_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything; a byte read in RD/LATCH is dropped unlatched.
    if (abort) begin
      state_d    = S_IDLE;
      sys_rd_d   = 1'b0;
      txd_en_d   = 1'b0;
      done_d     = 1'b0;
      txd_data_d = txd_data_q;
      byte_cnt_d = '0;
      gap_clr    = 1'b1;
    end
  end

  assign bus.sys_rd   = sys_rd_q;
  assign bus.txd_en   = txd_en_q;
  assign bus.txd_data = txd_data_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE);
  assign state_o      = state_q;

endmodule

// File: doc/txd_stream_sched.md
TXD_STREAM_SCHED -- requirements
Module: txd_stream_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 1024: bytes sent per burst, range 1..2047.
REQ-002 SHALL have parameter GAP_TICKS, default 16: clk_bps ticks between bytes, range 1..31.
REQ-003 SHALL have port clk  input  1: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1: one-cycle burst request, honoured only in IDLE.
REQ-006 SHALL have port abort  input  1: terminates the burst in progress.
REQ-007 SHALL have port clk_bps  input  1: one-cycle baud tick.
REQ-008 SHALL have port fifo_empty  input  1: source FIFO empty flag.
REQ-009 SHALL have port sys_data  input  8: FIFO read data, valid one cycle after the read is taken.
REQ-010 SHALL have port txd_busy  input  1: UART transmitter busy.
REQ-011 SHALL have port sys_rd  output  1: registered one-cycle FIFO read strobe.
REQ-012 SHALL have port txd_en  output  1: registered one-cycle UART load strobe.
REQ-013 SHALL have port txd_data  output  8: registered byte presented to the UART.
REQ-014 SHALL have port busy  output  1: high whenever the FSM is not in IDLE.
REQ-015 SHALL have port done  output  1: one-cycle pulse when a full burst completes.

Function
REQ-016 SHALL implement the FSM states IDLE, CHECK, RD, LATCH, SEND, GAP and DONE.
REQ-017 IDLE: SHALL move to CHECK when start=1; start outside IDLE SHALL be ignored.
REQ-018 CHECK: SHALL stay in CHECK while fifo_empty=1; when fifo_empty=0 it SHALL drive sys_rd=1 for exactly one cycle and move to RD.
REQ-019 RD: SHALL wait one cycle and then move to LATCH.
REQ-020 LATCH: SHALL register sys_data into txd_data and move to SEND.
REQ-021 SEND: SHALL wait while txd_busy=1; when txd_busy=0 it SHALL pulse txd_en for one cycle, increment the byte count, clear the gap counter and move to GAP.
REQ-022 GAP: SHALL increment the gap counter only on cycles where clk_bps=1.
REQ-023 GAP: when the gap counter reaches GAP_TICKS, the FSM SHALL move to DONE if the byte count equals BURST_LEN, otherwise to CHECK.
REQ-024 DONE: SHALL pulse done for one cycle, clear the byte count and return to IDLE.
REQ-025 Latency: with the FIFO non-empty and txd_busy=0, start sampled at edge k SHALL give sys_rd high during cycle k+1 and txd_en high during cycle k+4.
REQ-026 sys_rd SHALL be issued at most once per byte and never more than BURST_LEN times per burst; this is the no-over-read rule.
REQ-027 abort SHALL take priority over all transitions: the next state SHALL be IDLE, and sys_rd, txd_en and done SHALL be 0 from the abort cycle onward.
REQ-028 If abort arrives in RD or LATCH, the byte already read SHALL be discarded and txd_data SHALL hold its previous value.
REQ-029 start and abort together in IDLE SHALL leave the FSM in IDLE.
REQ-030 The byte counter SHALL be 11 bits and the gap counter 5 bits; neither SHALL wrap inside a burst.
REQ-031 A clk_bps tick arriving in any state other than GAP SHALL have no effect.

Reset
REQ-032 While rst_n=0, the FSM SHALL be in IDLE, both counters 0, sys_rd=0, txd_en=0, done=0, busy=0 and txd_data=8'h00, regardless of clk.
REQ-033 Reset asserted mid-burst SHALL abandon the burst; after release, no strobe SHALL occur until a new start.

Structure
REQ-034 The state encoding and the BURST_LEN/GAP_TICKS defaults SHALL live in a shared package, uart_stream_pkg.
REQ-035 The clk_bps gap counter SHALL be one sub-module, bps_gap_counter, with clear, tick input and reached output.

Verification
REQ-036 BURST_LEN=4, GAP_TICKS=2, FIFO preloaded with 8'hA1..8'hA4, start pulse -> txd_data sequence A1, A2, A3, A4; exactly 4 sys_rd and 4 txd_en; one done after the last gap.
REQ-037 fifo_empty=1 for 20 cycles after start, then 0 -> sys_rd stays 0 throughout, then fires on the first cycle after fifo_empty drops; busy=1 throughout.
REQ-038 txd_busy=1 for 50 cycles while in SEND -> txd_en held low for those 50 cycles, asserted in the first cycle with txd_busy=0.
REQ-039 abort on the cycle after the 2nd sys_rd of a 4-byte burst -> no further sys_rd or txd_en, done=0, busy=0 on the next cycle, txd_data still equal to byte 1.
REQ-040 rst_n pulled low in GAP, then a start pulse after release -> all outputs at reset values, and the new burst sends BURST_LEN fresh bytes.
REQ-041 Second start pulse mid-burst, plus clk_bps held high outside GAP -> total strobes equal to BURST_LEN and gap spacing unchanged.
